icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter INDEX_BITS, default 6, number of index bits; cache holds 2^INDEX_BITS direct-mapped one-word lines, tag = pc[31:INDEX_BITS+2].
REQ-002 clk_in  input  1  single clock; all state changes on rising edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-low.
REQ-004 rdy_in  input  1  global ready; low freezes all state and outputs.
REQ-005 pc_in  input  32  fetch address from fetcher; bits[1:0] ignored.
REQ-006 flush_in  input  1  invalidate all lines (fence.i / mispredict recovery).
REQ-007 inst_valid_out  output  1  one-cycle pulse; inst_out is the word at pc_in (serves as fetcher en_signal).
REQ-008 inst_out  output  32  instruction word, little-endian.
REQ-009 mem_req_out  output  1  request for memory bus to arbiter.
REQ-010 mem_grant_in  input  1  arbiter grant; once given, held until mem_req_out drops.
REQ-011 mem_a_out  output  32  byte read address to memory.
REQ-012 mem_din  input  8  read byte; valid the cycle after its address is presented.

Function
REQ-013 States: IDLE, WAIT, READ; storage: valid bit, tag, 32-bit data per line; counter cnt 0..4; latched miss address miss_pc.
REQ-014 IDLE, flush_in=0, pc_in hits (valid & tag match): next cycle inst_valid_out=1, inst_out=line data (hit latency 1 cycle), no memory request.
REQ-015 IDLE, flush_in=0, miss: latch miss_pc={pc_in[31:2],2'b00}; next state WAIT; inst_valid_out=0.
REQ-016 WAIT: mem_req_out=1; on cycle sampling mem_grant_in=1 go READ with cnt=0; otherwise stay, mem_a_out unchanged.
REQ-017 READ: mem_req_out=1; mem_a_out=miss_pc+cnt for cnt 0..3 (combinational from state/cnt); cnt increments each cycle.
REQ-018 READ cnt=c (c=1..4): capture mem_din into byte c-1 of fill word (byte0 = bits[7:0]).
REQ-019 READ cnt=4: write fill word, tag, valid=1 into line miss_pc index; next state IDLE; mem_req_out=0 next cycle.
REQ-020 Fill completion: inst_valid_out=1 and inst_out=fill word on the next cycle only if pc_in[31:2]==miss_pc[31:2] at cnt=4; otherwise no pulse, lookup resumes in IDLE.
REQ-021 Miss latency with immediate grant: miss detected cycle t, WAIT t+1, READ cnt0..4 at t+2..t+6, inst_valid_out at t+7.
REQ-022 flush_in=1 any state: all valid bits cleared next edge; WAIT/READ aborted to IDLE, no line write, no valid pulse; flush overrides hit and fill completion.
REQ-023 Outside WAIT/READ mem_req_out=0, mem_a_out holds last value; inst_out holds last value when inst_valid_out=0.
REQ-024 rdy_in=0: state, cnt, storage, outputs held; memory system is frozen by the same signal.
REQ-025 Arithmetic: miss_pc+cnt in 32 bits, no carry out of bits[1:0] since miss_pc word-aligned.

Reset
REQ-026 rst_in=0 asynchronously: state IDLE, cnt=0, all valid bits 0, inst_valid_out=0, inst_out=0, mem_req_out=0, mem_a_out=0, miss_pc=0; data/tag arrays need not reset.
REQ-027 Reset mid-fill abandons the fill; first lookup after release misses.

Verification
REQ-028 Reset, pc_in=0x0, grant immediate, bytes 0x13,0x00,0x00,0x00 -> mem_a_out 0,1,2,3; inst_out=0x00000013 pulse at t+7; repeat pc 0x0 -> pulse 1 cycle later, mem_req_out stays 0.
REQ-029 pc 0x000 filled, then pc 0x100 (same index, INDEX_BITS=6) -> miss, fill; pc 0x000 again -> miss (eviction).
REQ-030 mem_grant_in held low 3 cycles in WAIT -> mem_req_out=1, mem_a_out static, no pulse; pulse 6 cycles after grant cycle.
REQ-031 pc_in changed 0x4->0x8 mid-READ -> line 0x4 written, no pulse; 0x8 misses; later pc 0x4 hits.
REQ-032 flush_in pulse at READ cnt=2 -> mem_req_out=0 next cycle, no pulse; same pc then misses; rst_in low mid-fill -> all outputs 0 immediately.

Source files
------------

// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache, seen from the cache (slave)
// and from its environment (master).
interface icache_if;
    logic [31:0] pc_in;
    logic        flush_in;
    logic        inst_valid_out;
    logic [31:0] inst_out;
    logic        mem_req_out;
    logic        mem_grant_in;
    logic [31:0] mem_a_out;
    logic [7:0]  mem_din;

    modport slave (
        input  pc_in, flush_in, mem_grant_in, mem_din,
        output inst_valid_out, inst_out, mem_req_out, mem_a_out
    );

    modport master (
        output pc_in, flush_in, mem_grant_in, mem_din,
        input  inst_valid_out, inst_out, mem_req_out, mem_a_out
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per line, filled byte by byte over an 8-bit bus.
// state | meaning
// IDLE  | lookup pc_in; a hit pulses inst_valid_out next cycle, a miss latches miss_pc
// WAIT  | memory requested, waiting for the arbiter grant
// READ  | cnt 0..3 present byte addresses, cnt 1..4 capture bytes, cnt 4 writes the line
module icache #(
    parameter int INDEX_BITS = 6
) (
    input  logic    clk_in,
    input  logic    rst_in,
    input  logic    rdy_in,
    icache_if.slave bus
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, WAIT, READ} state_t;

    state_t           state;
    logic [2:0]       cnt;
    logic [31:0]      miss_pc;
    logic [31:0]      mem_a_q;
    logic [31:0]      inst_q;
    logic             inst_valid_q;
    logic [23:0]      fill;
    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    logic [31:0]           pc_word;
    logic [INDEX_BITS-1:0] pc_idx;
    logic [INDEX_BITS-1:0] miss_idx;
    logic [TAG_W-1:0]      pc_tag;
    logic [TAG_W-1:0]      miss_tag;
    logic                  hit;
    logic                  fill_done;
    logic                  same_word;
    logic                  presenting;
    logic [31:0]           rd_addr;
    logic [31:0]           fill_word;

    assign pc_word    = bus.pc_in & 32'hFFFF_FFFC;
    assign pc_idx     = pc_word[INDEX_BITS+1:2];
    assign pc_tag     = pc_word[31:INDEX_BITS+2];
    assign miss_idx   = miss_pc[INDEX_BITS+1:2];
    assign miss_tag   = miss_pc[31:INDEX_BITS+2];
    assign hit        = valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);
    assign same_word  = (pc_word[31:2] == miss_pc[31:2]);
    assign rd_addr    = miss_pc + {29'd0, cnt};
    assign fill_word  = {bus.mem_din, fill};
    assign presenting = (state == READ) && !cnt[2];
    assign fill_done  = rdy_in && !bus.flush_in && (state == READ) && (cnt == 3'd4);

    // The byte address is combinational during READ; elsewhere the last presented one is held.
    assign bus.mem_req_out    = (state != IDLE);
    assign bus.mem_a_out      = presenting ? rd_addr : mem_a_q;
    assign bus.inst_valid_out = inst_valid_q;
    assign bus.inst_out       = inst_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state        <= IDLE;
            cnt          <= '0;
            valid        <= '0;
            miss_pc      <= '0;
            mem_a_q      <= '0;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            fill         <= '0;
        end else if (rdy_in) begin
            inst_valid_q <= 1'b0;
            if (presenting) begin
                mem_a_q <= rd_addr;
            end
            if (bus.flush_in) begin
                valid <= '0;
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (hit) begin
                            inst_valid_q <= 1'b1;
                            inst_q       <= data_mem[pc_idx];
                        end else begin
                            miss_pc <= pc_word;
                            state   <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (bus.mem_grant_in) begin
                            state <= READ;
                            cnt   <= '0;
                        end
                    end
                    READ: begin
                        cnt <= cnt + 3'd1;
                        case (cnt)
                            3'd1: fill[7:0]   <= bus.mem_din;
                            3'd2: fill[15:8]  <= bus.mem_din;
                            3'd3: fill[23:16] <= bus.mem_din;
                            3'd4: begin
                                valid[miss_idx] <= 1'b1;
                                state           <= IDLE;
                                cnt             <= '0;
                                if (same_word) begin
                                    inst_valid_q <= 1'b1;
                                    inst_q       <= fill_word;
                                end
                            end
                            default: ;
                        endcase
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Tag and data arrays carry no reset; only the valid bits qualify them.
    always_ff @(posedge clk_in) begin
        if (fill_done) begin
            tag_mem[miss_idx]  <= miss_tag;
            data_mem[miss_idx] <= fill_word;
        end
    end
endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed fill/hit/evict/flush/reset scenarios followed by random fetch
// traffic, all checked cycle by cycle against a behavioural cache and memory model.
module tb_icache;
    localparam int IB = 6;
    localparam int NL = 1 << IB;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;

    icache_if bus ();

    icache #(.INDEX_BITS(IB)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: cache contents plus progress of the outstanding fill.
    bit          m_valid [NL];
    logic [31:0] m_tag   [NL];
    logic [31:0] m_data  [NL];
    bit          m_busy;
    bit          m_granted;
    int          m_rd;
    logic [31:0] m_addr;
    logic [31:0] m_last_a;
    bit          e_valid;
    logic [31:0] e_inst;

    logic [31:0] seen_a;
    int          gnt_cfg = 0;
    int          gnt_wait;
    bit          gnt_armed;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] h;
        if (a == 32'd0) return 8'h13;
        if (a < 32'd4) return 8'h00;
        h = (a * 32'd37) ^ (a >> 9) ^ 32'h0000_005A;
        return h[7:0];
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    task automatic model_reset();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        m_busy    = 1'b0;
        m_granted = 1'b0;
        m_rd      = 0;
        m_addr    = '0;
        m_last_a  = '0;
        e_valid   = 1'b0;
        e_inst    = '0;
        seen_a    = '0;
        gnt_armed = 1'b0;
        gnt_wait  = 0;
        bus.mem_grant_in = 1'b0;
        bus.mem_din      = '0;
    endtask

    task automatic model_step(input logic [31:0] pc, input bit fl, input bit g);
        int          idx;
        logic [31:0] tg;
        e_valid = 1'b0;
        if (fl) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            m_busy = 1'b0;
        end else if (!m_busy) begin
            idx = int'((pc >> 2) % NL);
            tg  = pc >> (IB + 2);
            if (m_valid[idx] && m_tag[idx] == tg) begin
                e_valid = 1'b1;
                e_inst  = m_data[idx];
            end else begin
                m_busy    = 1'b1;
                m_granted = 1'b0;
                m_addr    = pc & 32'hFFFF_FFFC;
            end
        end else if (!m_granted) begin
            if (g) begin
                m_granted = 1'b1;
                m_rd      = 0;
            end
        end else if (m_rd < 4) begin
            m_rd++;
        end else begin
            idx = int'((m_addr >> 2) % NL);
            m_valid[idx] = 1'b1;
            m_tag[idx]   = m_addr >> (IB + 2);
            m_data[idx]  = mem_word(m_addr);
            m_busy       = 1'b0;
            if ((pc >> 2) == (m_addr >> 2)) begin
                e_valid = 1'b1;
                e_inst  = mem_word(m_addr);
            end
        end
        if (m_busy && m_granted && m_rd < 4) m_last_a = m_addr + 32'(m_rd);
    endtask

    // One clock: apply inputs, step DUT and model, compare, then play memory and arbiter.
    task automatic cyc(input logic [31:0] pc, input bit fl, input bit rdy);
        bit g;
        bus.pc_in    = pc;
        bus.flush_in = fl;
        rdy_in       = rdy;
        g            = bus.mem_grant_in;
        @(posedge clk_in);
        #1;
        if (rdy) begin
            bus.mem_din = mem_byte(seen_a);
            model_step(pc, fl, g);
        end
        check_val("inst_valid", 32'(bus.inst_valid_out), 32'(e_valid));
        check_val("inst", bus.inst_out, e_inst);
        check_val("mem_req", 32'(bus.mem_req_out), 32'(m_busy));
        check_val("mem_a", bus.mem_a_out, m_last_a);
        seen_a = bus.mem_a_out;
        if (rdy) begin
            if (!bus.mem_req_out) begin
                bus.mem_grant_in = 1'b0;
                gnt_armed        = 1'b0;
            end else if (!bus.mem_grant_in) begin
                if (!gnt_armed) begin
                    gnt_armed = 1'b1;
                    gnt_wait  = (gnt_cfg < 0) ? int'($urandom_range(0, 3)) : gnt_cfg;
                end
                if (gnt_wait > 0) gnt_wait--;
                else bus.mem_grant_in = 1'b1;
            end
        end
    endtask

    // Cycles from the first clock with this pc until inst_valid_out is seen; -1 on timeout.
    task automatic run_until_pulse(input string tag, input logic [31:0] pc, input int limit,
                                   input int exp_lat);
        int lat = -1;
        for (int i = 1; i <= limit; i++) begin
            cyc(pc, 1'b0, 1'b1);
            if (bus.inst_valid_out) begin
                lat = i;
                break;
            end
        end
        check_val(tag, 32'(lat), 32'(exp_lat));
    endtask

    function automatic logic [31:0] pick_pc();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h4;
            2:       return 32'h8;
            3:       return 32'h100;
            4:       return $urandom_range(0, 127) << 2;
            default: return $urandom & 32'hFFFF_FFFC;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc;
        bit          fl;
        bit          rd;

        rst_in       = 1'b0;
        rdy_in       = 1'b1;
        bus.pc_in    = '0;
        bus.flush_in = 1'b0;
        model_reset();
        #12;
        check_val("rst_inst_valid", 32'(bus.inst_valid_out), 32'd0);
        check_val("rst_inst", bus.inst_out, 32'd0);
        check_val("rst_mem_req", 32'(bus.mem_req_out), 32'd0);
        check_val("rst_mem_a", bus.mem_a_out, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;

        // Cold miss with immediate grant, then a hit one cycle later.
        run_until_pulse("miss_lat_0", 32'h0, 20, 7);
        check_val("fill_word_0", bus.inst_out, 32'h0000_0013);
        run_until_pulse("hit_lat_0", 32'h0, 5, 1);
        check_val("hit_no_req", 32'(bus.mem_req_out), 32'd0);

        // Same index, different tag: eviction.
        run_until_pulse("miss_lat_100", 32'h100, 20, 7);
        run_until_pulse("evict_lat_0", 32'h0, 20, 7);

        // Grant withheld for three WAIT cycles.
        gnt_cfg = 3;
        run_until_pulse("slow_grant_lat", 32'h200, 30, 10);
        gnt_cfg = 0;

        // pc moves away mid-READ: line still written, no pulse for the old word.
        for (int i = 0; i < 4; i++) cyc(32'h4, 1'b0, 1'b1);
        run_until_pulse("redirect_lat_8", 32'h8, 20, 10);
        run_until_pulse("redirect_hit_4", 32'h4, 5, 1);

        // Flush at READ cnt=2 aborts the fill.
        for (int i = 0; i < 4; i++) cyc(32'hC, 1'b0, 1'b1);
        cyc(32'hC, 1'b1, 1'b1);
        check_val("flush_req_drop", 32'(bus.mem_req_out), 32'd0);
        run_until_pulse("after_flush_lat", 32'hC, 20, 7);
        cyc(32'h0, 1'b1, 1'b1);
        run_until_pulse("flushed_line_miss", 32'h0, 20, 7);

        // Freeze with rdy_in low during a fill.
        for (int i = 0; i < 3; i++) cyc(32'h20, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) cyc(32'h20, 1'b0, 1'b0);
        run_until_pulse("frozen_fill_lat", 32'h20, 20, 4);

        // Asynchronous reset in the middle of a fill.
        for (int i = 0; i < 3; i++) cyc(32'h10, 1'b0, 1'b1);
        #2;
        rst_in = 1'b0;
        #1;
        check_val("midfill_rst_valid", 32'(bus.inst_valid_out), 32'd0);
        check_val("midfill_rst_inst", bus.inst_out, 32'd0);
        check_val("midfill_rst_req", 32'(bus.mem_req_out), 32'd0);
        check_val("midfill_rst_a", bus.mem_a_out, 32'd0);
        model_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        run_until_pulse("post_rst_miss", 32'h0, 20, 7);

        // Random traffic.
        gnt_cfg = -1;
        pc      = 32'h0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 3) pc = pick_pc();
            fl = ($urandom_range(0, 39) == 0);
            rd = ($urandom_range(0, 9) != 0);
            cyc(pc, fl, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
